// File: rtl/simple_fifo_pkg.sv
// simple_fifo_pkg: default geometry shared by the FIFO and its users
package simple_fifo_pkg;
  localparam int DEF_FIFO_SIZE = 3;
  localparam int DEF_DATA_WIDTH = 8;
endpackage

// File: rtl/simple_fifo_rise_edge_detect.sv
// rise_edge_detect: one-cycle event on a low-to-high transition of a level strobe
module rise_edge_detect (
  input  logic clk,
  input  logic clear,
  input  logic sig,
  output logic evt
);
  logic sig_q;
  always_ff @(posedge clk or posedge clear) begin
    if (clear) sig_q <= 1'b0;
    else sig_q <= sig;
  end
  assign evt = sig & ~sig_q;
endmodule

// File: rtl/simple_fifo.sv
// simple_fifo: single-clock FIFO moving one word per rising edge of its push/pop strobes
module simple_fifo
  import simple_fifo_pkg::*;
#(
  parameter int FIFO_SIZE = DEF_FIFO_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  push_clock,
  input  logic                  pop_clock,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  pushed_last,
  output logic                  popped_last
);
  localparam int DEPTH = 1 << FIFO_SIZE;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [FIFO_SIZE-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_SIZE:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic push_evt, pop_evt, full, empty, do_push, do_pop;
  rise_edge_detect u_push (.clk(clk), .clear(clear), .sig(push_clock), .evt(push_evt));
  rise_edge_detect u_pop (.clk(clk), .clear(clear), .sig(pop_clock), .evt(pop_evt));
  // count never exceeds DEPTH, so its MSB alone marks full
  assign full = count_q[FIFO_SIZE];
  assign empty = count_q == '0;
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign do_pop = pop_evt & enable & ~empty;
  assign do_push = push_evt & enable & (~full | do_pop);
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d = (do_push && !do_pop) ? count_q + 1'b1 : (do_pop && !do_push) ? count_q - 1'b1 : count_q;
    out_data_d = do_pop ? mem_q[rd_ptr_q] : out_data_q;
  end
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      out_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      out_data_q <= out_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= in_data;
  end
  assign out_data = out_data_q;
  assign pushed_last = full;
  assign popped_last = empty;
endmodule

// File: tb/tb_simple_fifo.sv
// tb_simple_fifo: directed and random strobes checked against a queue model
module tb_simple_fifo;
  logic clk = 1'b0;
  logic clear, enable, push_clock, pop_clock;
  logic [7:0] in_data, out_data;
  logic pushed_last, popped_last;
  int checks = 0;
  int errors = 0;
  logic [7:0] mq[$];
  logic [7:0] exp_out;
  logic prev_push, prev_pop;
  always #5 clk = ~clk;
  simple_fifo #(.FIFO_SIZE(3), .DATA_WIDTH(8)) dut (
    .clk(clk), .clear(clear), .enable(enable), .push_clock(push_clock), .pop_clock(pop_clock),
    .in_data(in_data), .out_data(out_data), .pushed_last(pushed_last), .popped_last(popped_last)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_state();
    chk("out_data", out_data, exp_out);
    chk("pushed_last", pushed_last, mq.size() == 8);
    chk("popped_last", popped_last, mq.size() == 0);
  endtask
  task automatic cyc(input logic p, input logic o, input logic e, input logic [7:0] d);
    logic pe, oe;
    push_clock = p;
    pop_clock = o;
    enable = e;
    in_data = d;
    @(posedge clk);
    pe = p && !prev_push;
    oe = o && !prev_pop;
    prev_push = p;
    prev_pop = o;
    if (e) begin
      if (oe && mq.size() > 0) exp_out = mq.pop_front();
      if (pe && mq.size() < 8) mq.push_back(d);
    end
    @(negedge clk);
    check_state();
  endtask
  task automatic push(input logic [7:0] d, input int hold = 1);
    for (int i = 0; i < hold; i++) cyc(1'b1, 1'b0, 1'b1, d);
    cyc(1'b0, 1'b0, 1'b1, d);
  endtask
  task automatic pop();
    cyc(1'b0, 1'b1, 1'b1, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
  endtask
  task automatic do_clear();
    push_clock = 1'b0;
    pop_clock = 1'b0;
    #2 clear = 1'b1;
    #1;
    mq.delete();
    exp_out = 8'h00;
    prev_push = 1'b0;
    prev_pop = 1'b0;
    check_state();
    @(negedge clk);
    clear = 1'b0;
  endtask
  initial begin
    clear = 1'b1;
    enable = 1'b0;
    push_clock = 1'b0;
    pop_clock = 1'b0;
    in_data = 8'h00;
    exp_out = 8'h00;
    prev_push = 1'b0;
    prev_pop = 1'b0;
    repeat (2) @(negedge clk);
    check_state();
    clear = 1'b0;
    push(8'hAC, 1);
    push(8'h61, 2);
    chk("two_stored", {30'd0, pushed_last, popped_last}, 32'd0);
    pop();
    chk("pop_ac", out_data, 8'hAC);
    pop();
    chk("pop_61", out_data, 8'h61);
    chk("empty_after2", popped_last, 1'b1);
    pop();
    chk("pop_empty_hold", out_data, 8'h61);
    for (int i = 0; i < 8; i++) push(8'(i));
    chk("full_after8", pushed_last, 1'b1);
    push(8'hFF);
    for (int i = 0; i < 8; i++) begin
      pop();
      chk("drain_order", out_data, 32'(i));
    end
    for (int i = 0; i < 5; i++) push(8'($urandom));
    repeat (5) pop();
    for (int i = 0; i < 8; i++) push(8'($urandom));
    repeat (8) pop();
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    cyc(1'b1, 1'b1, 1'b1, 8'h55);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("full_pushpop_out", out_data, 8'h10);
    chk("full_pushpop_full", pushed_last, 1'b1);
    repeat (8) pop();
    chk("full_pushpop_last", out_data, 8'h55);
    cyc(1'b1, 1'b1, 1'b1, 8'h55);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("empty_pushpop_out", out_data, 8'h55);
    chk("empty_pushpop_stored", popped_last, 1'b0);
    pop();
    for (int i = 0; i < 3; i++) push(8'hA0 + 8'(i));
    do_clear();
    chk("clear_out", out_data, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) push(8'hB0 + 8'(i));
    cyc(1'b1, 1'b1, 1'b0, 8'hEE);
    cyc(1'b0, 1'b0, 1'b0, 8'hEE);
    cyc(1'b1, 1'b0, 1'b0, 8'hCC);
    cyc(1'b1, 1'b0, 1'b1, 8'hCC);
    cyc(1'b0, 1'b0, 1'b1, 8'hCC);
    chk("enable_low_out", out_data, 8'h00);
    repeat (3) pop();
    chk("enable_low_last", out_data, 8'hB2);
    chk("enable_low_empty", popped_last, 1'b1);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_clear();
      else cyc(1'($urandom), 1'($urandom), $urandom_range(0, 7) != 0, 8'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
